// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the fetch PC, runs the req/gnt/rvalid handshake with
// instruction memory and feeds a small prefetch FIFO that presents words to the decoder.
module fetch_stage #(
  parameter int                      ADDRESS_BITS = 32,
  parameter logic [ADDRESS_BITS-1:0] BOOT_ADDR    = '0,
  parameter int                      FIFO_DEPTH   = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  output logic                    instr_req_o,
  output logic [ADDRESS_BITS-1:0] instr_addr_o,
  input  logic                    instr_gnt_i,
  input  logic                    instr_rvalid_i,
  input  logic [31:0]             instr_rdata_i,
  input  logic                    stall_i,
  input  logic                    pc_s_d_i,
  input  logic [ADDRESS_BITS-1:0] target_pc_i,
  input  logic                    jalr_redirect_i,
  input  logic [ADDRESS_BITS-1:0] jalr_target_i,
  output logic                    valid_o,
  output logic [31:0]             instruction_o,
  output logic [ADDRESS_BITS-1:0] pc_o,
  output logic [ADDRESS_BITS-1:0] pc_next_o
);

  localparam int                      PTR_W   = $clog2(FIFO_DEPTH);
  localparam int                      CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam int                      LVL_W   = CNT_W + 1;
  localparam logic [31:0]             NOP     = 32'h0000_0013;
  localparam logic [ADDRESS_BITS-1:0] PC_STEP = ADDRESS_BITS'(4);

  typedef struct packed {
    logic [ADDRESS_BITS-1:0] pc;
    logic [31:0]             instr;
  } entry_t;

  entry_t                  r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]        r_rd_ptr;
  logic [PTR_W-1:0]        r_wr_ptr;
  logic [CNT_W-1:0]        r_count;
  logic [ADDRESS_BITS-1:0] r_fetch_pc;
  logic [ADDRESS_BITS-1:0] r_tag;
  logic                    r_outstanding;
  logic                    r_discard;

  logic                    w_valid;
  logic                    w_pop;
  logic                    w_redirect;
  logic [ADDRESS_BITS-1:0] w_target;
  logic [ADDRESS_BITS-1:0] w_target_aligned;
  logic                    w_rsp;
  logic                    w_push;
  logic                    w_inflight;
  logic [LVL_W-1:0]        w_level;
  logic                    w_req;
  logic                    w_gnt;
  entry_t                  w_head;

  assign w_valid          = (r_count != '0);
  assign w_pop            = w_valid && !stall_i;
  assign w_redirect       = jalr_redirect_i || (pc_s_d_i && w_pop);
  assign w_target         = jalr_redirect_i ? jalr_target_i : target_pc_i;
  assign w_target_aligned = w_target & ~ADDRESS_BITS'(3);

  // A response only counts while a transaction is open; late rvalids after reset fall out here.
  assign w_rsp      = instr_rvalid_i && r_outstanding;
  assign w_push     = w_rsp && !r_discard && !w_redirect;
  assign w_inflight = r_outstanding && !r_discard;

  // Occupancy the new request's response would land into: live entries plus any word still coming.
  assign w_level = {1'b0, r_count} + LVL_W'(w_inflight) - LVL_W'(w_pop);
  // NOTE: gated by rst_n combinationally so no request leaves while reset is held.
  assign w_req   = rst_n && !w_redirect && (!r_outstanding || w_rsp)
                   && (w_level < LVL_W'(FIFO_DEPTH));
  assign w_gnt   = w_req && instr_gnt_i;

  // NOTE: non-blocking assignments throughout so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_fetch_pc    <= BOOT_ADDR;
      r_tag         <= BOOT_ADDR;
      r_outstanding <= 1'b0;
      r_discard     <= 1'b0;
      r_count       <= '0;
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
    end else begin
      if (w_redirect)  r_fetch_pc <= w_target_aligned;
      else if (w_gnt)  r_fetch_pc <= r_fetch_pc + PC_STEP;

      if (w_gnt) begin
        r_outstanding <= 1'b1;
        r_tag         <= r_fetch_pc;
      end else if (w_rsp) begin
        r_outstanding <= 1'b0;
      end

      if (w_redirect)  r_discard <= r_outstanding && !instr_rvalid_i;
      else if (w_rsp)  r_discard <= 1'b0;

      if (w_redirect) begin
        r_count  <= '0;
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
      end else begin
        r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end

      assert (!(w_push && !w_pop && (r_count == CNT_W'(FIFO_DEPTH))));
    end
  end

  // NOTE: storage carries no reset; r_count alone says which entries are live.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= '{pc: r_tag, instr: instr_rdata_i};
  end

  assign w_head        = r_mem[r_rd_ptr];
  assign instr_req_o   = w_req;
  assign instr_addr_o  = r_fetch_pc;
  assign valid_o       = w_valid;
  assign instruction_o = w_valid ? w_head.instr : NOP;
  assign pc_o          = w_valid ? w_head.pc : '0;
  assign pc_next_o     = pc_o + PC_STEP;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: a behavioural memory with random grant/latency and a program-order
// model of the PC stream, plus directed scenarios for reset, stall, redirects and late data.
module tb_fetch_stage;

  localparam int            AW   = 32;
  localparam logic [AW-1:0] BOOT = 32'h0;
  localparam logic [31:0]   NOP  = 32'h0000_0013;

  logic          clk = 1'b0;
  logic          rst_n, instr_req_o, instr_gnt_i, instr_rvalid_i;
  logic          stall_i, pc_s_d_i, jalr_redirect_i, valid_o;
  logic [AW-1:0] instr_addr_o, target_pc_i, jalr_target_i, pc_o, pc_next_o;
  logic [31:0]   instr_rdata_i, instruction_o;

  int checks = 0;
  int errors = 0;

  // Stimulus knobs
  bit            k_rst, k_stall, k_pcsd, k_jalr;
  logic [AW-1:0] k_tgt, k_jtgt;
  int            gnt_pct, lat_lo, lat_hi;

  // Reference model: next PC the decoder must see, next address the fetcher must ask for,
  // and the single transaction the memory is working on.
  logic [AW-1:0] exp_pc, exp_req, m_addr;
  bit            m_pend;
  int            m_dly;
  int            nopop, max_nopop;

  // Per-cycle snapshot of the DUT
  bit            s_req, s_valid, s_rv, s_gnt;
  logic [AW-1:0] s_addr, s_pc, s_pcn;
  logic [31:0]   s_instr;

  fetch_stage #(.ADDRESS_BITS(AW), .BOOT_ADDR(BOOT), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .instr_req_o(instr_req_o), .instr_addr_o(instr_addr_o), .instr_gnt_i(instr_gnt_i),
    .instr_rvalid_i(instr_rvalid_i), .instr_rdata_i(instr_rdata_i),
    .stall_i(stall_i), .pc_s_d_i(pc_s_d_i), .target_pc_i(target_pc_i),
    .jalr_redirect_i(jalr_redirect_i), .jalr_target_i(jalr_target_i),
    .valid_o(valid_o), .instruction_o(instruction_o), .pc_o(pc_o), .pc_next_o(pc_next_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  function automatic logic [AW-1:0] inc4(input logic [AW-1:0] a);
    return a + 32'd4;
  endfunction

  function automatic logic [AW-1:0] align(input logic [AW-1:0] a);
    return a & ~32'h3;
  endfunction

  function automatic logic [AW-1:0] rand_target();
    if ($urandom_range(3) == 0) return 32'hFFFF_FFF0 | ($urandom() & 32'hF);
    return $urandom() & 32'h0000_0FFF;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: present the memory response and decoder/ALU inputs, sample the DUT,
  // answer the request, check against the model and advance it.
  task automatic step();
    bit pop, redir;
    @(posedge clk); #1;
    s_rv            = m_pend && (m_dly == 0);
    instr_rvalid_i  = s_rv;
    instr_rdata_i   = s_rv ? mem_word(m_addr) : $urandom();
    rst_n           = k_rst;
    stall_i         = k_stall;
    pc_s_d_i        = k_pcsd;
    target_pc_i     = k_tgt;
    jalr_redirect_i = k_jalr;
    jalr_target_i   = k_jtgt;
    #1;
    s_req   = instr_req_o;
    s_addr  = instr_addr_o;
    s_valid = valid_o;
    s_pc    = pc_o;
    s_pcn   = pc_next_o;
    s_instr = instruction_o;
    s_gnt   = s_req && ($urandom_range(99) < gnt_pct);
    instr_gnt_i = s_gnt;

    if (k_rst) begin
      pop   = s_valid && !k_stall;
      redir = k_jalr || (k_pcsd && pop);
      if (s_valid) begin
        check("head_instr", s_instr, mem_word(s_pc));
        check("pc_next", s_pcn, inc4(s_pc));
      end else begin
        check("idle_nop", s_instr, NOP);
        check("idle_pc", s_pc, 0);
        check("idle_pc_next", s_pcn, 4);
      end
      check("addr_align", s_addr[1:0], 2'b00);
      if (s_req) begin
        check("one_outstanding", !(m_pend && !s_rv), 1);
        check("req_addr", s_addr, exp_req);
      end
      if (redir) check("req_low_on_redirect", s_req, 0);
      if (pop)   check("program_order", s_pc, exp_pc);

      if (k_jalr) begin
        exp_pc  = align(k_jtgt);
        exp_req = align(k_jtgt);
      end else if (k_pcsd && pop) begin
        exp_pc  = align(k_tgt);
        exp_req = align(k_tgt);
      end else begin
        if (pop)   exp_pc  = inc4(s_pc);
        if (s_gnt) exp_req = inc4(exp_req);
      end
      nopop = pop ? 0 : nopop + 1;
      if (nopop > max_nopop) max_nopop = nopop;
    end else begin
      check("req_in_reset", s_req, 0);
      exp_pc  = BOOT;
      exp_req = BOOT;
      nopop   = 0;
    end

    if (s_rv) m_pend = 1'b0;
    if (s_gnt) begin
      m_pend = 1'b1;
      m_addr = s_addr;
      m_dly  = $urandom_range(lat_hi, lat_lo);
    end else if (m_pend && m_dly > 0) begin
      m_dly--;
    end
  endtask

  task automatic do_reset();
    k_rst = 0; k_stall = 0; k_pcsd = 0; k_jalr = 0;
    gnt_pct = 100; lat_lo = 0; lat_hi = 0;
    step();
    step();
    check("rst_req", s_req, 0);
    check("rst_addr", s_addr, BOOT);
    check("rst_valid", s_valid, 0);
    check("rst_instr", s_instr, NOP);
    check("rst_pc", s_pc, 0);
    check("rst_pc_next", s_pcn, 4);
    k_rst = 1;
  endtask

  task automatic wait_valid(input string tag, input int bound);
    int n;
    n = 0;
    step();
    while (!s_valid && n < bound) begin
      step();
      n++;
    end
    check(tag, s_valid, 1);
  endtask

  initial begin
    logic [AW-1:0] held_pc;
    int            drained;

    rst_n = 0; instr_gnt_i = 0; instr_rvalid_i = 0; instr_rdata_i = '0;
    stall_i = 0; pc_s_d_i = 0; target_pc_i = '0; jalr_redirect_i = 0; jalr_target_i = '0;
    k_tgt = '0; k_jtgt = '0; m_pend = 0; m_addr = '0; m_dly = 0;
    exp_pc = BOOT; exp_req = BOOT; nopop = 0; max_nopop = 0;

    // Boot with zero-wait memory: back-to-back requests, first valid in cycle 3.
    do_reset();
    step();
    check("c1_req", s_req, 1);
    check("c1_addr", s_addr, BOOT);
    check("c1_valid", s_valid, 0);
    step();
    check("c2_req", s_req, 1);
    check("c2_addr", s_addr, 32'h4);
    check("c2_valid", s_valid, 0);
    step();
    check("c3_valid", s_valid, 1);
    check("c3_pc", s_pc, 32'h0);
    check("c3_pc_next", s_pcn, 32'h4);
    for (int i = 0; i < 8; i++) begin
      step();
      check("stream_valid", s_valid, 1);
      check("stream_req", s_req, 1);
    end

    // Stall: FIFO fills, requests stop, head holds; then exactly two entries drain.
    k_stall = 1;
    step();
    held_pc = s_pc;
    for (int i = 0; i < 5; i++) begin
      step();
      check("stall_pc_hold", s_pc, held_pc);
    end
    check("stall_req_low", s_req, 0);
    check("stall_valid", s_valid, 1);
    k_stall = 0;
    gnt_pct = 0;
    drained = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (s_valid) drained++;
    end
    check("stall_drain_count", drained, 2);

    // Decoder redirect when popping pc 0x10 to 0x42.
    do_reset();
    for (int i = 0; i < 6; i++) step();
    k_pcsd = 1; k_tgt = 32'h42;
    step();
    check("dec_pop_valid", s_valid, 1);
    check("dec_pop_pc", s_pc, 32'h10);
    k_pcsd = 0;
    step();
    check("dec_req", s_req, 1);
    check("dec_req_addr", s_addr, 32'h40);
    check("dec_flushed", s_valid, 0);
    wait_valid("dec_wait", 20);
    check("dec_first_pc", s_pc, 32'h40);

    // JALR while the 0x20 fetch is outstanding and its data comes back late.
    do_reset();
    for (int i = 0; i < 8; i++) step();
    lat_lo = 3; lat_hi = 3;
    step();
    check("jalr_req_20", s_addr, 32'h20);
    check("jalr_gnt_20", s_gnt, 1);
    lat_lo = 0; lat_hi = 0;
    k_jalr = 1; k_jtgt = 32'h100;
    step();
    check("jalr_req_low", s_req, 0);
    k_jalr = 0;
    step();
    check("jalr_wait1_req", s_req, 0);
    check("jalr_flushed", s_valid, 0);
    step();
    check("jalr_wait2_req", s_req, 0);
    wait_valid("jalr_wait", 20);
    check("jalr_first_pc", s_pc, 32'h100);
    check("jalr_first_instr", s_instr, mem_word(32'h100));

    // JALR and popped decoder redirect in the same cycle: JALR wins.
    do_reset();
    for (int i = 0; i < 4; i++) step();
    k_jalr = 1; k_jtgt = 32'h200; k_pcsd = 1; k_tgt = 32'h80;
    step();
    check("prio_pop", s_valid, 1);
    k_jalr = 0; k_pcsd = 0;
    wait_valid("prio_wait", 20);
    check("prio_first_pc", s_pc, 32'h200);

    // Reset during an outstanding fetch; its rvalid shows up after release.
    do_reset();
    for (int i = 0; i < 3; i++) step();
    lat_lo = 1; lat_hi = 1;
    step();
    check("mid_gnt", s_gnt, 1);
    lat_lo = 0; lat_hi = 0;
    k_rst = 0;
    step();
    k_rst = 1;
    step();
    check("late_rv_seen", s_rv, 1);
    check("late_req", s_req, 1);
    check("late_addr", s_addr, BOOT);
    check("late_valid0", s_valid, 0);
    step();
    check("late_valid1", s_valid, 0);
    step();
    check("refetch_valid", s_valid, 1);
    check("refetch_pc", s_pc, BOOT);
    check("refetch_instr", s_instr, mem_word(BOOT));

    // Random traffic against the model.
    do_reset();
    max_nopop = 0;
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) begin
        gnt_pct = $urandom_range(100, 30);
        lat_hi  = $urandom_range(3, 0);
      end
      k_stall = ($urandom_range(3) == 0);
      k_pcsd  = ($urandom_range(9) == 0);
      k_tgt   = rand_target();
      k_jalr  = ($urandom_range(49) == 0);
      k_jtgt  = rand_target();
      step();
    end
    check("liveness", (max_nopop <= 200), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage of the RV32IM pipeline, directly upstream of the decoder. Owns the architectural fetch PC, runs a request/grant/response handshake with instruction memory, buffers returned words in a small prefetch FIFO, and presents `instruction_o` / `pc_o` / `pc_next_o` to the decoder. It accepts the decoder's static-prediction redirect (`target_pc`, `pc_s_d`) and a late JALR redirect from the ALU.

## Interface
- `ADDRESS_BITS`, 32, PC / memory address width
- `BOOT_ADDR`, 0, first fetch address after reset (word aligned)
- `FIFO_DEPTH`, 2, prefetch entries (power of two, ≥2)
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  synchronous, active-low reset
- `instr_req_o`  out  1  memory request
- `instr_addr_o`  out  ADDRESS_BITS  request address, bits [1:0] always 0
- `instr_gnt_i`  in  1  request accepted this cycle
- `instr_rvalid_i`  in  1  response data valid
- `instr_rdata_i`  in  32  response instruction word
- `stall_i`  in  1  downstream hold (hazard / encryption loop); head not consumed
- `pc_s_d_i`  in  1  decoder redirect select
- `target_pc_i`  in  ADDRESS_BITS  decoder redirect target
- `jalr_redirect_i`  in  1  ALU-resolved JALR redirect
- `jalr_target_i`  in  ADDRESS_BITS  JALR target
- `valid_o`  out  1  FIFO head valid
- `instruction_o`  out  32  head instruction; 32'h0000_0013 (NOP) when `valid_o`=0
- `pc_o`  out  ADDRESS_BITS  head PC; 0 when invalid
- `pc_next_o`  out  ADDRESS_BITS  `pc_o`+4 (wraps mod 2^ADDRESS_BITS)

Reset: one clock `clk`; synchronous active-low reset `rst_n`.

## Operation
- State: `fetch_pc` (next address to request), `outstanding` (0/1), `discard` flag, FIFO of {pc, instr}, count 0..FIFO_DEPTH.
- Pop: `valid_o && !stall_i`.
- Request rule: `instr_req_o` = !redirect && (!outstanding || instr_rvalid_i) && (count − pop + outstanding_kept) < FIFO_DEPTH; at most one transaction outstanding.
- On `instr_req_o && instr_gnt_i`: `outstanding`←1, FIFO tag for that transaction = `fetch_pc`, `fetch_pc`←`fetch_pc`+4.
- Request held: `instr_addr_o` stable while `instr_req_o` high without grant.
- On `instr_rvalid_i`: `outstanding`←0; if `discard`, drop data and clear `discard`; else push {tag, rdata}.
- Redirect sources, priority: `jalr_redirect_i` (unconditional) > `pc_s_d_i` (effective only when pop) > sequential.
- On redirect: FIFO flushed (count←0), `fetch_pc`←target with [1:0] forced 0, `instr_req_o` low that cycle, `discard`←1 if a transaction is outstanding and its rvalid is not in this cycle; an rvalid arriving in the redirect cycle is dropped.
- Push and pop same cycle: count unchanged. Push to full FIFO never happens by request rule (assertion).
- Decoder redirect to its own PC (encryption hold) is a legal refetch loop.

## Timing
- Reset values: `instr_req_o`=0, `instr_addr_o`=BOOT_ADDR, `valid_o`=0, `instruction_o`=NOP, `pc_o`=0, `pc_next_o`=4, `fetch_pc`=BOOT_ADDR, `outstanding`=0, `discard`=0.
- First request: first cycle after `rst_n` high.
- FIFO registered: push at edge after `instr_rvalid_i`; `valid_o` high the next cycle. Gnt-to-`valid_o` ≥2 cycles.
- Zero-wait memory (gnt same cycle, rvalid next): sustained one instruction per cycle with `stall_i`=0.
- Redirect: new-target request no earlier than cycle after redirect, and only once `outstanding`=0.
- `rst_n` low mid-transaction: all state returns to reset values at that edge; late rvalid after reset ignored (`outstanding`=0).

## Test plan
- Reset release, BOOT_ADDR=0, zero-wait memory -> requests 0,4,8,… on consecutive cycles; `valid_o` first high cycle 3 with `pc_o`=0, `pc_next_o`=4.
- `stall_i` held high 6 cycles -> FIFO fills to 2, `instr_req_o` drops, `pc_o` constant; release -> in-order output, no loss or duplicate.
- Pop at pc 0x10 with `pc_s_d_i`=1, `target_pc_i`=0x42 -> FIFO flushed, next request 0x40, next valid `pc_o`=0x40.
- `jalr_redirect_i` to 0x100 while request to 0x20 outstanding with rvalid 3 cycles late -> 0x20 data dropped, first valid `pc_o`=0x100.
- Same cycle `jalr_redirect_i` (0x200) and popped `pc_s_d_i` (0x80) -> fetch resumes at 0x200.
- `rst_n` low during outstanding request, memory returns rvalid afterwards -> `valid_o` stays 0, refetch from BOOT_ADDR.
